// File: rtl/msu_mcu_ctrl.sv
// MCU-side sequencer for the MSU: fills the data-seek buffer from storage, opens
// audio tracks and applies control updates, acknowledging each with a status strobe.
module msu_mcu_ctrl #(
   parameter int FILL_LEN   = 8192,
   parameter int STROBE_LEN = 4
) (
   input  logic        clkin,
   input  logic        rst,
   input  logic [7:0]  status_in,
   input  logic [31:0] addr_in,
   input  logic [15:0] track_in,
   input  logic [7:0]  src_data,
   input  logic        src_valid,
   output logic        src_ready,
   output logic        req_data,
   output logic [31:0] req_addr,
   output logic        req_audio,
   output logic [15:0] req_track,
   input  logic        audio_ok,
   input  logic        audio_err,
   output logic [13:0] pgm_address,
   output logic [7:0]  pgm_data,
   output logic        pgm_we,
   output logic [5:0]  status_set_bits,
   output logic [5:0]  status_reset_bits,
   output logic        status_reset_we,
   output logic [13:0] msu_address_ext,
   output logic        msu_address_ext_write,
   output logic        busy
);
   localparam int TW = $clog2(2 * STROBE_LEN + 1);
   localparam logic [TW-1:0] T_HI_LAST  = TW'(STROBE_LEN - 1);
   localparam logic [TW-1:0] T_ALL_LAST = TW'(2 * STROBE_LEN - 1);
   localparam logic [14:0]   FILL_LAST  = 15'(FILL_LEN - 1);

   typedef enum logic [3:0] {
      IDLE, DREQ, DFILL, DPTR, AREQ, AWAIT, CTRL, STROBE, GUARD
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   req_addr_q, req_addr_d;
   logic [15:0]   req_track_q, req_track_d;
   logic [13:0]   offset_q, offset_d;
   logic [14:0]   count_q, count_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [13:0]   pgm_address_q, pgm_address_d;
   logic [7:0]    pgm_data_q, pgm_data_d;
   logic          pgm_we_q, pgm_we_d;
   logic          src_ready_q, src_ready_d;
   logic          req_data_q, req_data_d;
   logic          req_audio_q, req_audio_d;
   logic [5:0]    set_q, set_d, clr_q, clr_d;
   logic          status_we_q, status_we_d;
   logic [13:0]   ext_q, ext_d;
   logic          ext_we_q, ext_we_d;
   logic          accept;
   logic          unused_status;

   assign unused_status = ^{status_in[7], status_in[4], status_in[3]};
   assign accept        = src_valid & src_ready_q;

   always_comb begin
      state_d       = state_q;
      req_addr_d    = req_addr_q;
      req_track_d   = req_track_q;
      offset_d      = offset_q;
      count_d       = count_q;
      timer_d       = timer_q;
      pgm_address_d = pgm_address_q;
      pgm_data_d    = pgm_data_q;
      set_d         = set_q;
      clr_d         = clr_q;
      ext_d         = ext_q;
      pgm_we_d      = 1'b1;
      src_ready_d   = 1'b0;
      req_data_d    = 1'b0;
      req_audio_d   = 1'b0;
      status_we_d   = 1'b0;
      ext_we_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (status_in[5]) begin
               req_addr_d = addr_in;
               offset_d   = addr_in[13:0];
               count_d    = '0;
               req_data_d = 1'b1;
               state_d    = DREQ;
            end else if (status_in[6]) begin
               req_track_d = track_in;
               req_audio_d = 1'b1;
               state_d     = AREQ;
            end else if (status_in[0]) begin
               state_d = CTRL;
            end
         end
         DREQ: begin
            src_ready_d = 1'b1;
            state_d     = DFILL;
         end
         DFILL: begin
            src_ready_d = 1'b1;
            if (accept) begin
               pgm_we_d      = 1'b0;
               pgm_data_d    = src_data;
               pgm_address_d = offset_q;
               offset_d      = offset_q + 14'd1;
               count_d       = count_q + 15'd1;
               // Last byte: ready drops together with the final write strobe.
               if (count_q == FILL_LAST) begin
                  src_ready_d = 1'b0;
                  ext_d       = req_addr_q[13:0];
                  ext_we_d    = 1'b1;
                  timer_d     = '0;
                  state_d     = DPTR;
               end
            end
         end
         DPTR: begin
            timer_d  = timer_q + 1'b1;
            ext_we_d = (timer_q < T_HI_LAST);
            if (timer_q == T_ALL_LAST) begin
               set_d       = 6'b000000;
               clr_d       = 6'b010000;
               status_we_d = 1'b1;
               timer_d     = '0;
               state_d     = STROBE;
            end
         end
         AREQ: state_d = AWAIT;
         AWAIT: begin
            if (audio_err) begin
               set_d       = 6'b001000;
               clr_d       = 6'b100000;
               status_we_d = 1'b1;
               timer_d     = '0;
               state_d     = STROBE;
            end else if (audio_ok) begin
               set_d       = 6'b000000;
               clr_d       = 6'b101000;
               status_we_d = 1'b1;
               timer_d     = '0;
               state_d     = STROBE;
            end
         end
         CTRL: begin
            set_d       = {3'b000, status_in[2:1], 1'b0};
            clr_d       = {3'b000, ~status_in[2:1], 1'b1};
            status_we_d = 1'b1;
            timer_d     = '0;
            state_d     = STROBE;
         end
         STROBE: begin
            timer_d     = timer_q + 1'b1;
            status_we_d = (timer_q < T_HI_LAST);
            if (timer_q == T_HI_LAST) begin
               timer_d = '0;
               state_d = GUARD;
            end
         end
         GUARD: begin
            // Lets the MSU's cleared start bit settle before IDLE re-arbitrates.
            timer_d = timer_q + 1'b1;
            if (timer_q == T_HI_LAST) begin
               timer_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         state_q       <= IDLE;
         req_addr_q    <= '0;
         req_track_q   <= '0;
         offset_q      <= '0;
         count_q       <= '0;
         timer_q       <= '0;
         pgm_address_q <= '0;
         pgm_data_q    <= '0;
         pgm_we_q      <= 1'b1;
         src_ready_q   <= 1'b0;
         req_data_q    <= 1'b0;
         req_audio_q   <= 1'b0;
         set_q         <= '0;
         clr_q         <= '0;
         status_we_q   <= 1'b0;
         ext_q         <= '0;
         ext_we_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_addr_q    <= req_addr_d;
         req_track_q   <= req_track_d;
         offset_q      <= offset_d;
         count_q       <= count_d;
         timer_q       <= timer_d;
         pgm_address_q <= pgm_address_d;
         pgm_data_q    <= pgm_data_d;
         pgm_we_q      <= pgm_we_d;
         src_ready_q   <= src_ready_d;
         req_data_q    <= req_data_d;
         req_audio_q   <= req_audio_d;
         set_q         <= set_d;
         clr_q         <= clr_d;
         status_we_q   <= status_we_d;
         ext_q         <= ext_d;
         ext_we_q      <= ext_we_d;
      end
   end

   assign src_ready             = src_ready_q;
   assign req_data              = req_data_q;
   assign req_addr              = req_addr_q;
   assign req_audio             = req_audio_q;
   assign req_track             = req_track_q;
   assign pgm_address           = pgm_address_q;
   assign pgm_data              = pgm_data_q;
   assign pgm_we                = pgm_we_q;
   assign status_set_bits       = set_q;
   assign status_reset_bits     = clr_q;
   assign status_reset_we       = status_we_q;
   assign msu_address_ext       = ext_q;
   assign msu_address_ext_write = ext_we_q;
   assign busy                  = (state_q != IDLE);
endmodule

// File: tb/tb_msu_mcu_ctrl.sv
// Directed bench for msu_mcu_ctrl with FILL_LEN=8, STROBE_LEN=4; a small MSU/storage
// model clears served start bits on each status strobe and streams A0,A1,... bytes.
module tb_msu_mcu_ctrl;
   logic        clkin = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  status_in = '0;
   logic [31:0] addr_in = '0;
   logic [15:0] track_in = '0;
   logic [7:0]  src_data = '0;
   logic        src_valid = 1'b0;
   logic        audio_ok = 1'b0, audio_err = 1'b0;
   logic        src_ready, req_data, req_audio, pgm_we, status_reset_we, msu_address_ext_write, busy;
   logic [31:0] req_addr;
   logic [15:0] req_track;
   logic [13:0] pgm_address, msu_address_ext;
   logic [7:0]  pgm_data;
   logic [5:0]  status_set_bits, status_reset_bits;

   int n_checks = 0, n_pass = 0, n_fail = 0;

   // per-transaction observations
   int n_req_data, n_req_audio, n_wr, n_ext_hi, n_we_hi, n_strobe, mask_unstable;
   int last_ext_cyc, req_audio_cyc;
   bit timed_out, last_wr_ready;
   logic [13:0] ext_val;
   logic [13:0] wr_addr [16];
   logic [7:0]  wr_data [16];
   logic [5:0]  st_set [4];
   logic [5:0]  st_rst [4];
   int          st_start [4];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   msu_mcu_ctrl #(.FILL_LEN(8), .STROBE_LEN(4)) dut (
      .clkin(clkin), .rst(rst), .status_in(status_in), .addr_in(addr_in), .track_in(track_in),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
      .req_data(req_data), .req_addr(req_addr), .req_audio(req_audio), .req_track(req_track),
      .audio_ok(audio_ok), .audio_err(audio_err),
      .pgm_address(pgm_address), .pgm_data(pgm_data), .pgm_we(pgm_we),
      .status_set_bits(status_set_bits), .status_reset_bits(status_reset_bits),
      .status_reset_we(status_reset_we), .msu_address_ext(msu_address_ext),
      .msu_address_ext_write(msu_address_ext_write), .busy(busy)
   );

   always #5 clkin = ~clkin;

   // Runs until the DUT is idle with no start bits pending (or max_cyc expires).
   // audio_mode bit0 = pulse audio_ok, bit1 = pulse audio_err, audio_dly cycles after req_audio.
   // abort_at != 0 asserts rst as soon as that many writes have been observed.
   task automatic run_txn(input int max_cyc, input bit toggle, input int audio_mode,
                          input int audio_dly, input int abort_at);
      int  src_idx = 0, aud_cnt = 0;
      bit  aud_armed = 0, prev_we = 0;
      n_req_data = 0; n_req_audio = 0; n_wr = 0; n_ext_hi = 0; n_we_hi = 0; n_strobe = 0;
      mask_unstable = 0; last_ext_cyc = -1; req_audio_cyc = -1; timed_out = 1;
      last_wr_ready = 1; ext_val = '0;
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         @(negedge clkin);
         audio_ok = 1'b0;
         audio_err = 1'b0;
         if (req_data) n_req_data++;
         if (req_audio) begin
            n_req_audio++; aud_armed = 1; aud_cnt = 0;
            if (req_audio_cyc < 0) req_audio_cyc = cyc;
         end else if (aud_armed) begin
            aud_cnt++;
            if (aud_cnt == audio_dly) begin
               aud_armed = 0;
               audio_ok  = (audio_mode & 1) != 0;
               audio_err = (audio_mode & 2) != 0;
            end
         end
         if (!pgm_we) begin
            if (n_wr < 16) begin wr_addr[n_wr] = pgm_address; wr_data[n_wr] = pgm_data; end
            n_wr++;
            last_wr_ready = src_ready;
         end
         if (msu_address_ext_write) begin n_ext_hi++; ext_val = msu_address_ext; last_ext_cyc = cyc; end
         if (status_reset_we) begin
            n_we_hi++;
            if (!prev_we) begin
               if (n_strobe < 4) begin
                  st_set[n_strobe] = status_set_bits;
                  st_rst[n_strobe] = status_reset_bits;
                  st_start[n_strobe] = cyc;
               end
               n_strobe++;
               if (status_reset_bits[4]) status_in[5] = 1'b0;
               if (status_reset_bits[5]) status_in[6] = 1'b0;
               if (status_reset_bits[0]) status_in[0] = 1'b0;
            end else if (n_strobe <= 4 &&
                         (status_set_bits !== st_set[n_strobe-1] || status_reset_bits !== st_rst[n_strobe-1])) begin
               mask_unstable++;
            end
         end
         prev_we = status_reset_we;
         if (abort_at != 0 && n_wr == abort_at) begin
            rst = 1'b1;
            timed_out = 0;
            return;
         end
         src_valid = toggle ? (cyc % 2 == 0) : 1'b1;
         src_data  = 8'(8'hA0 + src_idx);
         if (src_ready && src_valid) src_idx++;
         if (cyc > 2 && !busy && (status_in & 8'h61) == 8'h00) begin
            timed_out = 0;
            break;
         end
      end
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clkin);
      chk("rst_pgm_we", pgm_we, 1'b1);
      chk("rst_pulses", {src_ready, req_data, req_audio, status_reset_we, msu_address_ext_write}, 5'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_masks", {status_set_bits, status_reset_bits}, 12'h000);
      chk("rst_addrs", {req_addr, req_track, pgm_address, msu_address_ext}, 76'h0);
      rst = 1'b0;
      @(negedge clkin);
      chk("idle_busy", busy, 1'b0);

      // basic fill from 0x1234
      addr_in = 32'h0000_1234;
      status_in = 8'h20;
      run_txn(300, 0, 0, 0, 0);
      chk("t1_done", timed_out, 1'b0);
      chk("t1_req_data", n_req_data, 1);
      chk("t1_req_addr", req_addr, 32'h0000_1234);
      chk("t1_nwr", n_wr, 8);
      for (int k = 0; k < 8; k++) begin
         chk("t1_wr_addr", wr_addr[k], 14'(14'h1234 + k));
         chk("t1_wr_data", wr_data[k], 8'(8'hA0 + k));
      end
      chk("t1_last_ready", last_wr_ready, 1'b0);
      chk("t1_ext_val", ext_val, 14'h1234);
      chk("t1_ext_hi", n_ext_hi, 4);
      chk("t1_ext_gap", st_start[0] - last_ext_cyc - 1, 4);
      chk("t1_nstrobe", n_strobe, 1);
      chk("t1_we_hi", n_we_hi, 4);
      chk("t1_set", st_set[0], 6'h00);
      chk("t1_rst", st_rst[0], 6'h10);
      chk("t1_stable", mask_unstable, 0);

      // wrap across 3FFF with src_valid toggling
      addr_in = 32'h5A5A_FFFD;
      status_in = 8'h20;
      run_txn(300, 1, 0, 0, 0);
      chk("t2_done", timed_out, 1'b0);
      chk("t2_req_addr", req_addr, 32'h5A5A_FFFD);
      chk("t2_nwr", n_wr, 8);
      for (int k = 0; k < 8; k++) begin
         chk("t2_wr_addr", wr_addr[k], 14'(14'h3FFD + k));
         chk("t2_wr_data", wr_data[k], 8'(8'hA0 + k));
      end
      chk("t2_ext_val", ext_val, 14'h3FFD);

      // audio request, ok after 20 cycles
      track_in = 16'h0102;
      status_in = 8'h40;
      run_txn(300, 0, 1, 20, 0);
      chk("t3_done", timed_out, 1'b0);
      chk("t3_req_track", req_track, 16'h0102);
      chk("t3_req_audio", n_req_audio, 1);
      chk("t3_nwr", n_wr, 0);
      chk("t3_set", st_set[0], 6'h00);
      chk("t3_rst", st_rst[0], 6'h28);
      chk("t3_we_hi", n_we_hi, 4);

      // ok and err together: err wins
      track_in = 16'h0BEE;
      status_in = 8'h40;
      run_txn(300, 0, 3, 3, 0);
      chk("t4_done", timed_out, 1'b0);
      chk("t4_set", st_set[0], 6'h08);
      chk("t4_rst", st_rst[0], 6'h20);

      // data and audio together: data first, audio after guard
      addr_in = 32'h0000_0100;
      track_in = 16'h0007;
      status_in = 8'h60;
      run_txn(400, 0, 1, 5, 0);
      chk("t5_done", timed_out, 1'b0);
      chk("t5_nstrobe", n_strobe, 2);
      chk("t5_rst0", st_rst[0], 6'h10);
      chk("t5_rst1", st_rst[1], 6'h28);
      chk("t5_nwr", n_wr, 8);
      chk("t5_audio_after_guard", req_audio_cyc - st_start[0], 9);

      // control update with status[2:1]=01
      status_in = 8'h03;
      run_txn(100, 0, 0, 0, 0);
      chk("t6_done", timed_out, 1'b0);
      chk("t6_set", st_set[0], 6'h02);
      chk("t6_rst", st_rst[0], 6'h05);
      chk("t6_we_hi", n_we_hi, 4);

      // reset after 3 of 8 bytes, then full refill
      addr_in = 32'h0000_0200;
      status_in = 8'h20;
      run_txn(200, 0, 0, 0, 3);
      chk("t7_abort_reached", timed_out, 1'b0);
      @(negedge clkin);
      chk("t7_idle", busy, 1'b0);
      chk("t7_pgm_we", pgm_we, 1'b1);
      chk("t7_no_strobe", {status_reset_we, msu_address_ext_write, src_ready}, 3'b000);
      chk("t7_we_count", n_we_hi, 0);
      chk("t7_nwr", n_wr, 3);
      rst = 1'b0;
      run_txn(300, 0, 0, 0, 0);
      chk("t7_refill_done", timed_out, 1'b0);
      chk("t7_refill_nwr", n_wr, 8);
      for (int k = 0; k < 8; k++) begin
         chk("t7_wr_addr", wr_addr[k], 14'(14'h0200 + k));
         chk("t7_wr_data", wr_data[k], 8'(8'hA0 + k));
      end
      chk("t7_rst_bits", st_rst[0], 6'h10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/msu_mcu_ctrl.md
MSU_MCU_CTRL -- requirements
Module: msu_mcu_ctrl

Interface
REQ-001 Parameter: FILL_LEN, default 8192, number of bytes per data-seek buffer fill (1..16384).
REQ-002 Parameter: STROBE_LEN, default 4, high time and minimum low time in cycles of status_reset_we and msu_address_ext_write.
REQ-003 Port: clkin  in  1  sole clock; all logic on posedge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: status_in  in  8  MSU status: [6]=audio_start, [5]=data_start, [3:1]=audio_ctrl, [0]=ctrl_start.
REQ-006 Port: addr_in  in  32  MSU data seek address.
REQ-007 Port: track_in  in  16  MSU requested track.
REQ-008 Port: src_data  in  8  fill byte from storage.
REQ-009 Port: src_valid  in  1  src_data valid.
REQ-010 Port: src_ready  out  1  byte accepted when src_valid & src_ready.
REQ-011 Port: req_data  out  1  one-cycle pulse requesting storage stream from req_addr.
REQ-012 Port: req_addr  out  32  latched addr_in.
REQ-013 Port: req_audio  out  1  one-cycle pulse requesting track req_track.
REQ-014 Port: req_track  out  16  latched track_in.
REQ-015 Port: audio_ok  in  1  one-cycle track-open success pulse.
REQ-016 Port: audio_err  in  1  one-cycle track-open failure pulse.
REQ-017 Port: pgm_address  out  14  data-buffer write address.
REQ-018 Port: pgm_data  out  8  data-buffer write byte.
REQ-019 Port: pgm_we  out  1  data-buffer write strobe, active-low.
REQ-020 Port: status_set_bits  out  6  MSU status set mask.
REQ-021 Port: status_reset_bits  out  6  MSU status reset mask.
REQ-022 Port: status_reset_we  out  1  status update strobe; MSU acts on its rising edge.
REQ-023 Port: msu_address_ext  out  14  new MSU read pointer.
REQ-024 Port: msu_address_ext_write  out  1  pointer load strobe; MSU acts on its rising edge.
REQ-025 Port: busy  out  1  high whenever state != IDLE.

Function
REQ-026 States SHALL be IDLE, DREQ, DFILL, DPTR, AREQ, AWAIT, CTRL, STROBE, GUARD.
REQ-027 IDLE priority SHALL be data_start, then audio_start, then ctrl_start; all are level-sensitive.
REQ-028 On data_start, the block SHALL latch req_addr=addr_in, set write offset=addr_in[13:0], set byte count=0, and go to DREQ.
REQ-029 DREQ SHALL pulse req_data for exactly one cycle, then enter DFILL.
REQ-030 In DFILL, src_ready SHALL be 1; each accepted byte SHALL drive pgm_we=0 for one cycle with pgm_data=src_data and pgm_address=offset.
REQ-031 Each accepted byte SHALL increment offset modulo 16384 (wraps 3FFF->0000) and increment the count.
REQ-032 src_valid low SHALL stall DFILL without a write.
REQ-033 When the count reaches FILL_LEN, the block SHALL drop src_ready in the same cycle the last byte is written and enter DPTR.
REQ-034 DPTR SHALL drive msu_address_ext=req_addr[13:0] and hold msu_address_ext_write high STROBE_LEN cycles, then low STROBE_LEN cycles.
REQ-035 DPTR SHALL then load set=000000, reset=010000 (data_busy/data_start) and enter STROBE.
REQ-036 On audio_start, the block SHALL latch req_track=track_in and go to AREQ, which pulses req_audio for one cycle and then enters AWAIT.
REQ-037 AWAIT SHALL wait indefinitely for audio_ok or audio_err.
REQ-038 audio_ok SHALL load set=000000, reset=101000 (audio busy/start, error).
REQ-039 audio_err SHALL load set=001000, reset=100000.
REQ-040 If audio_ok and audio_err arrive in the same cycle, audio_err SHALL win.
REQ-041 On ctrl_start, CTRL SHALL load set={000,status_in[2:1],0} and reset={000,~status_in[2:1],1}.
REQ-042 STROBE SHALL hold the masks stable and raise status_reset_we for STROBE_LEN cycles.
REQ-043 GUARD SHALL hold status_reset_we low for STROBE_LEN cycles, then return to IDLE, so the cleared start bit is seen before re-arbitration.
REQ-044 Outside DFILL, pgm_we SHALL be 1 and src_ready SHALL be 0.
REQ-045 All state-changing outputs SHALL be registered with no combinational input-to-output paths.

Reset
REQ-046 During rst, state SHALL go to IDLE.
REQ-047 During rst: pgm_we=1; src_ready, req_data, req_audio, status_reset_we, msu_address_ext_write=0.
REQ-048 During rst: all masks, addresses, counts, req_addr and req_track=0.
REQ-049 rst mid-fill SHALL abort immediately, leaving already-written buffer bytes intact and issuing no status strobe.

Verification
REQ-050 FILL_LEN=8, addr_in=0x00001234, data_start=1, src_valid always 1 -> one req_data pulse; 8 writes to 0x1234..0x123B; ext write of 0x1234; set=00, reset=0x10 strobe 4 cycles.
REQ-051 FILL_LEN=8, addr_in[13:0]=0x3FFD, src_valid toggling 1/0 -> writes to 3FFD,3FFE,3FFF,0000..0004 only on valid cycles.
REQ-052 audio_start, track_in=0x0102, audio_ok after 20 cycles -> req_track=0x0102, one req_audio pulse, reset=0x28 strobe.
REQ-053 audio_ok and audio_err in the same cycle -> set=0x08, reset=0x20.
REQ-054 data_start and audio_start both high -> data fill completes first, then audio served after GUARD; ctrl_start with status[2:1]=01 -> set=0x02, reset=0x05.
REQ-055 rst asserted after 3 of 8 fill bytes -> next cycle IDLE, pgm_we=1, no strobe; re-request refills all 8 bytes.
